// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the packet round-robin AXI-Stream arbiter.
package axis_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    // Index following cur, wrapping at n.
    function automatic int unsigned next_idx(input int unsigned cur, input int unsigned n);
        return (cur + 1 >= n) ? 0 : cur + 1;
    endfunction

endpackage

// File: rtl/axis_rr_pick.sv
// Combinational round-robin picker: first requester after 'last', modulo NUM_M.
module axis_rr_pick
    import axis_arb_pkg::*;
#(
    parameter int unsigned NUM_M = 4,
    parameter int unsigned ID_W  = 2
) (
    input  logic [NUM_M-1:0] req,
    input  logic [ID_W-1:0]  last,
    output logic             found,
    output logic [ID_W-1:0]  idx
);

    logic [2*NUM_M-1:0] dbl_req;
    logic [2*NUM_M-1:0] win_mask;
    int unsigned        start;

    // Unroll the request vector twice and keep a NUM_M-wide window starting
    // just after 'last'; the lowest set bit of that window is the winner.
    always_comb begin
        dbl_req  = {req, req};
        start    = next_idx(32'(last), NUM_M);
        win_mask = '0;
        found    = 1'b0;
        idx      = '0;
        for (int unsigned j = 0; j < 2 * NUM_M; j++) begin
            win_mask[j] = dbl_req[j] && (j >= start) && (j < start + NUM_M);
        end
        for (int unsigned j = 0; j < 2 * NUM_M; j++) begin
            if (win_mask[j] && !found) begin
                found = 1'b1;
                idx   = ID_W'((j >= NUM_M) ? (j - NUM_M) : j);
            end
        end
    end

endmodule

// File: rtl/axis_pkt_rr_arbiter.sv
// Packet-level round-robin arbiter: NUM_M AXI-Stream masters onto one slave
// through a single full-throughput output register.
module axis_pkt_rr_arbiter
    import axis_arb_pkg::*;
#(
    parameter int unsigned NUM_M  = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ID_W   = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                    axis_aclk,
    input  logic                    axis_areset,
    input  logic [NUM_M-1:0]        s_axis_tvalid,
    input  logic [NUM_M*DATA_W-1:0] s_axis_tdata,
    input  logic [NUM_M-1:0]        s_axis_tlast,
    output logic [NUM_M-1:0]        s_axis_tready,
    output logic                    m_axis_tvalid,
    output logic [DATA_W-1:0]       m_axis_tdata,
    output logic                    m_axis_tlast,
    output logic [ID_W-1:0]         m_axis_tid,
    input  logic                    m_axis_tready,
    output logic                    busy,
    output logic [ID_W-1:0]         grant_idx,
    output logic [CNT_W-1:0]        pkt_cnt
);

    state_t              state_q, state_d;
    logic [ID_W-1:0]     grant_q, grant_d;
    logic                pick_found;
    logic [ID_W-1:0]     pick_idx;
    logic                out_free;
    logic                accept;
    logic                g_valid;
    logic                g_last;
    logic [DATA_W-1:0]   g_data;

    axis_rr_pick #(
        .NUM_M (NUM_M),
        .ID_W  (ID_W)
    ) u_pick (
        .req   (s_axis_tvalid),
        .last  (grant_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Select the granted master's beat and derive the handshake terms.
    always_comb begin
        g_valid  = s_axis_tvalid[grant_q];
        g_last   = s_axis_tlast[grant_q];
        g_data   = s_axis_tdata[grant_q*DATA_W +: DATA_W];
        out_free = !m_axis_tvalid || m_axis_tready;
        accept   = (state_q == XFER) && g_valid && out_free;
    end

    // Next-state, grant update and per-master ready.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        s_axis_tready = '0;
        unique case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    state_d = XFER;
                end
            end
            XFER: begin
                s_axis_tready[grant_q] = out_free;
                if (accept && g_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and grant registers.
    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            state_q <= IDLE;
            grant_q <= ID_W'(NUM_M - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    // Output register: reload on accept (even while draining), else empty on transfer.
    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tid    <= '0;
        end else if (accept) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= g_data;
            m_axis_tlast  <= g_last;
            m_axis_tid    <= grant_q;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    // Count packets whose final beat has left downstream; wraps naturally.
    always_ff @(posedge axis_aclk) begin
        if (axis_areset) begin
            pkt_cnt <= '0;
        end else if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
            pkt_cnt <= pkt_cnt + 1'b1;
        end
    end

    assign busy      = (state_q == XFER);
    assign grant_idx = grant_q;

endmodule
